// File: rtl/i2c_target.sv
// I2C target with a byte-wide register-file port: address match, pointer load,
// burst writes and burst reads with auto-incrementing, wrapping pointer.
module i2c_target #(
    parameter int         ADDRWIDTH = 6,
    parameter logic [6:0] DEV_ADDR  = 7'h50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [ADDRWIDTH-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_we,
    input  logic [7:0]           reg_rdata,
    output logic                 busy
);

    // State names carry an ST_ prefix so ST_DEV_ADDR cannot collide with the DEV_ADDR parameter
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK
    } state_t;

    state_t               state, state_n;
    logic                 scl_s1, scl_s2, scl_d;
    logic                 sda_s1, sda_s2, sda_d;
    logic                 scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [7:0]           shift, shift_n, shift_in;
    logic                 rw, rw_n;
    logic                 sda_oe_n, reg_we_n, busy_n;
    logic [7:0]           reg_wdata_n;
    logic [ADDRWIDTH-1:0] reg_addr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign shift_in  = {shift[6:0], sda_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            reg_we    <= 1'b0;
            reg_wdata <= 8'd0;
            reg_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rw        <= rw_n;
            sda_oe    <= sda_oe_n;
            reg_we    <= reg_we_n;
            reg_wdata <= reg_wdata_n;
            reg_addr  <= reg_addr_n;
            busy      <= busy_n;
        end
    end

    // In the ACK states bit_cnt is a phase flag: 0 = waiting for the fall that
    // starts driving ACK, 1 = waiting for the fall that ends it.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rw_n        = rw;
        sda_oe_n    = sda_oe;
        reg_we_n    = 1'b0;
        reg_wdata_n = reg_wdata;
        reg_addr_n  = reg_addr;
        busy_n      = busy;

        if (reg_we)
            reg_addr_n = reg_addr + ADDRWIDTH'(1);

        if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (shift_in[7:1] == DEV_ADDR) begin
                                state_n = ST_DEV_ACK;
                                rw_n    = shift_in[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else begin
                            bit_cnt_n = 4'd0;
                            if (rw) begin
                                state_n  = ST_READ;
                                shift_n  = reg_rdata;
                                sda_oe_n = ~reg_rdata[7];
                            end else begin
                                state_n  = ST_REG_ADDR;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n  = 4'd0;
                            reg_addr_n = shift_in[ADDRWIDTH-1:0];
                            state_n    = ST_REG_ACK;
                        end
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = shift_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        reg_we_n    = 1'b1;
                        reg_wdata_n = shift;
                        sda_oe_n    = 1'b1;
                        bit_cnt_n   = 4'd0;
                        state_n     = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n   = 1'b0;
                        bit_cnt_n  = 4'd0;
                        reg_addr_n = reg_addr + ADDRWIDTH'(1);
                        state_n    = ST_READ_ACK;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        shift_n  = {shift[6:0], 1'b0};
                        sda_oe_n = ~shift[6];
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            bit_cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_n = 4'd0;
                        shift_n   = reg_rdata;
                        sda_oe_n  = ~reg_rdata[7];
                        state_n   = ST_READ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master, a behavioural register/pointer
// model, a fixed vector table, random transactions and a mid-write reset.
module tb_i2c_target;

    localparam int Q = 6;

    typedef struct packed {
        logic [1:0]  kind;     // 0 write, 1 pointer-set + repeated-START read, 2 current-pointer read
        logic [6:0]  dev;
        logic [7:0]  ptr;
        logic [2:0]  nbytes;
        logic [31:0] data;     // write bytes, lowest byte sent first
        logic        exp_ack;
        logic [7:0]  exp_ptr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, scl, sda_m, sda_line;
    logic        sda_oe, reg_we, busy;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;

    logic [7:0]  regs [64];
    logic [7:0]  model_regs [64];
    logic [5:0]  model_ptr;
    logic [13:0] we_log [$];
    int          checks = 0, errors = 0;
    int          oe_count, busy_count, we_double = 0, oe_high_viol = 0;
    logic        mon_en = 1'b0, we_prev = 1'b0, scl_prev = 1'b1, oe_prev = 1'b0;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    always #5 clk = ~clk;

    i2c_target #(.ADDRWIDTH(6), .DEV_ADDR(7'h50)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file behind the target, plus bus-rule monitors
    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            regs[reg_addr] = reg_wdata;
            we_log.push_back({reg_addr, reg_wdata});
        end
        if (mon_en) begin
            if (reg_we === 1'b1 && we_prev === 1'b1) we_double++;
            if (scl && scl_prev && sda_oe === 1'b1 && oe_prev === 1'b0) oe_high_viol++;
            if (sda_oe === 1'b1) oe_count++;
            if (busy === 1'b1) busy_count++;
        end
        we_prev  = reg_we;
        scl_prev = scl;
        oe_prev  = sda_oe;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_m = b;    wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        @(negedge clk) s = sda_line;
        wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
    endtask

    function automatic logic [7:0] predict_ptr(input vec_t v, input logic [5:0] cur);
        if (v.dev != 7'h50) return {2'b00, cur};
        if (v.kind == 2'd2) return 8'((int'(cur) + int'(v.nbytes)) % 64);
        return 8'((int'(v.ptr) % 64 + int'(v.nbytes)) % 64);
    endfunction

    function automatic vec_t mk(input logic [1:0] kind, input logic [6:0] dev, input logic [7:0] ptr,
                                input logic [2:0] n, input logic [31:0] data,
                                input logic exp_ack, input logic [7:0] exp_ptr);
        vec_t v;
        v.kind = kind; v.dev = dev; v.ptr = ptr; v.nbytes = n; v.data = data;
        v.exp_ack = exp_ack; v.exp_ptr = exp_ptr;
        return v;
    endfunction

    task automatic read_burst(input int n, inout logic [5:0] mptr);
        logic [7:0] got;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, got);
            check_output("read_data", got, model_regs[mptr]);
            mptr = mptr + 6'd1;
        end
        @(negedge clk);
        check_output("nack_idle_oe", sda_oe, 1'b0);
        check_output("nack_idle_busy", busy, 1'b0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic        ack;
        logic [7:0]  d;
        logic [5:0]  mptr;
        logic [13:0] exp_log [$];
        we_log.delete();
        oe_count   = 0;
        busy_count = 0;
        mptr       = model_ptr;
        bus_start();
        case (v.kind)
            2'd0: begin
                write_byte({v.dev, 1'b0}, ack); check_output("dev_ack", ack, v.exp_ack);
                write_byte(v.ptr, ack);         check_output("ptr_ack", ack, v.exp_ack);
                if (v.exp_ack) mptr = v.ptr[5:0];
                for (int i = 0; i < int'(v.nbytes); i++) begin
                    d = v.data[8*i +: 8];
                    write_byte(d, ack);
                    check_output("data_ack", ack, v.exp_ack);
                    if (v.exp_ack) begin
                        exp_log.push_back({mptr, d});
                        model_regs[mptr] = d;
                        mptr = mptr + 6'd1;
                    end
                end
            end
            2'd1: begin
                write_byte({v.dev, 1'b0}, ack); check_output("dev_ack", ack, v.exp_ack);
                if (v.exp_ack) begin
                    write_byte(v.ptr, ack); check_output("ptr_ack", ack, 1'b1);
                    mptr = v.ptr[5:0];
                    bus_start();
                    write_byte({v.dev, 1'b1}, ack); check_output("rd_dev_ack", ack, 1'b1);
                    read_burst(int'(v.nbytes), mptr);
                end
            end
            default: begin
                write_byte({v.dev, 1'b1}, ack); check_output("dev_ack", ack, v.exp_ack);
                if (v.exp_ack) read_burst(int'(v.nbytes), mptr);
            end
        endcase
        bus_stop();
        check_output("we_count", we_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < we_log.size(); i++)
            check_output("we_entry", we_log[i], exp_log[i]);
        check_output("busy_seen", busy_count != 0, v.exp_ack);
        if (!v.exp_ack) check_output("oe_quiet", oe_count, 0);
        check_output("busy_after_stop", busy, 1'b0);
        check_output("oe_after_stop", sda_oe, 1'b0);
        check_output("ptr_final", reg_addr, v.exp_ptr);
        model_ptr = mptr;
    endtask

    initial begin
        vec_t vecs [9];
        vec_t rv;
        logic ack, s;
        logic [7:0] r;

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r = 8'($urandom);
            regs[i] = r;
            model_regs[i] = r;
        end
        model_ptr = 6'd0;

        vecs[0] = mk(2'd0, 7'h50, 8'h05, 3'd1, 32'h0000_003C, 1'b1, 8'd6);
        vecs[1] = mk(2'd1, 7'h50, 8'h05, 3'd1, 32'h0,         1'b1, 8'd6);
        vecs[2] = mk(2'd0, 7'h51, 8'h05, 3'd1, 32'h0000_0077, 1'b0, 8'd6);
        vecs[3] = mk(2'd0, 7'h50, 8'h3F, 3'd2, 32'h0000_2211, 1'b1, 8'd1);
        vecs[4] = mk(2'd0, 7'h50, 8'h02, 3'd3, 32'h00CC_BBAA, 1'b1, 8'd5);
        vecs[5] = mk(2'd1, 7'h50, 8'h02, 3'd3, 32'h0,         1'b1, 8'd5);
        vecs[6] = mk(2'd0, 7'h50, 8'hC7, 3'd1, 32'h0000_005A, 1'b1, 8'd8);
        vecs[7] = mk(2'd2, 7'h50, 8'h00, 3'd2, 32'h0,         1'b1, 8'd10);
        vecs[8] = mk(2'd2, 7'h51, 8'h00, 3'd1, 32'h0,         1'b0, 8'd10);

        wait_clk(3);
        @(negedge clk);
        check_output("rst_sda_oe", sda_oe, 1'b0);
        check_output("rst_reg_we", reg_we, 1'b0);
        check_output("rst_reg_wdata", reg_wdata, 8'h00);
        check_output("rst_reg_addr", reg_addr, 6'd0);
        check_output("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_clk(4);
        mon_en = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        $display("[TB] random transactions");
        for (int i = 0; i < 12; i++) begin
            rv.kind   = 2'($urandom_range(0, 2));
            rv.dev    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
            rv.ptr    = 8'($urandom);
            rv.nbytes = 3'($urandom_range(1, 3));
            rv.data   = $urandom;
            rv.exp_ack = (rv.dev == 7'h50);
            rv.exp_ptr = predict_ptr(rv, model_ptr);
            apply_stimulus(rv);
        end

        $display("[TB] reset during write data");
        we_log.delete();
        bus_start();
        write_byte(8'hA0, ack); check_output("rstw_dev_ack", ack, 1'b1);
        write_byte(8'h10, ack); check_output("rstw_ptr_ack", ack, 1'b1);
        for (int i = 7; i >= 4; i--) send_bit(i[0], s);
        @(posedge clk); reset = 1'b1;
        @(posedge clk); reset = 1'b0;
        @(negedge clk);
        check_output("rstw_sda_oe", sda_oe, 1'b0);
        check_output("rstw_busy", busy, 1'b0);
        check_output("rstw_reg_addr", reg_addr, 6'd0);
        wait_clk(4);
        check_output("rstw_no_we", we_log.size(), 0);
        model_ptr = 6'd0;
        sda_m = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(2 * Q);
        apply_stimulus(mk(2'd0, 7'h50, 8'h12, 3'd1, 32'h0000_0099, 1'b1, 8'h13));

        check_output("we_single_cycle", we_double, 0);
        check_output("oe_rise_while_scl_high", oe_high_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
